// File: rtl/rv64_seq_divider.sv
// rv64_seq_divider: radix-2 restoring RV64M divider, single-cycle special cases under `RV_DIV_FAST_SPECIAL_EN
module rv64_seq_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem, rem_sh, trial, rem_nx;
  logic [XLEN-1:0] quo, quo_nx, dvs, a_abs, b_abs, mag, fix, spec_res;
  logic            rem_sel, neg, a_neg, b_neg, special;
  always_comb begin
    a_neg = ~op[0] & dividend[XLEN-1];
    b_neg = ~op[0] & divisor[XLEN-1];
    a_abs = a_neg ? -dividend : dividend;
    b_abs = b_neg ? -divisor : divisor;
    rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
    trial = rem_sh - {1'b0, dvs};
    rem_nx = trial[XLEN] ? rem_sh : trial;
    quo_nx = {quo[XLEN-2:0], ~trial[XLEN]};
    mag = rem_sel ? rem_nx[XLEN-1:0] : quo_nx;
    fix = neg ? -mag : mag;
`ifdef RV_DIV_FAST_SPECIAL_EN
    special = (divisor == '0) | (~op[0] & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor));
    spec_res = (divisor == '0) ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
`else
    special = 1'b0;
    spec_res = '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg <= 1'b0;
      rem_sel <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start && state != CALC) begin
      rem_sel <= op[1];
      neg <= op[1] ? a_neg : (a_neg ^ b_neg) & (divisor != '0);
      dvs <= b_abs;
      quo <= a_abs;
      rem <= '0;
      cnt <= '0;
      state <= special ? DONE : CALC;
      busy <= ~special;
      done <= special;
      if (special) result <= spec_res;
    end else if (state == CALC) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(XLEN-1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        result <= fix;
      end
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rv64_seq_divider.sv
// tb_rv64_seq_divider: table vectors, random ops against an arithmetic model, and handshake corner sequences
module tb_rv64_seq_divider;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] dividend = '0, divisor = '0;
  logic        busy, done;
  logic [63:0] result;
  int errors = 0, checks = 0;
  typedef struct {
    logic [1:0]  op;
    logic [63:0] a, b, exp;
  } vec_t;
  vec_t vecs[12];
  rv64_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .abort(abort), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : ONES;
    if (!o[0] && a == MIN && b == ONES) return o[1] ? 64'd0 : MIN;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
`ifdef RV_DIV_FAST_SPECIAL_EN
    return (b == 0 || (!o[0] && a == MIN && b == ONES)) ? 0 : 64;
`else
    return 64 + 0 * int'(o) + 0 * int'(a[0]) + 0 * int'(b[0]);
`endif
  endfunction
  task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op = o;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  // lat = rising edges after the acceptance edge until done is visible
  task automatic wait_done(output int lat, output logic b0);
    lat = 0;
    @(negedge clk);
    b0 = busy;
    while (!done && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic run(input string name, input logic [1:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp);
    int lat;
    logic b0;
    int el;
    el = exp_lat(o, a, b);
    issue(o, a, b);
    wait_done(lat, b0);
    chk({name, " result"}, result, exp);
    chk({name, " latency"}, 64'(lat), 64'(el));
    chk({name, " busy after accept"}, 64'(b0), 64'(el != 0));
    chk({name, " busy in done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({name, " done pulse width"}, 64'(done), 64'd0);
  endtask
  initial begin
    int lat, nd, first;
    logic b0;
    logic [1:0] o;
    logic [63:0] a, b;
    logic [63:0] r14;
    vecs[0]  = '{2'b01, 64'd100, 64'd7, 64'd14};
    vecs[1]  = '{2'b11, 64'd100, 64'd7, 64'd2};
    vecs[2]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES};
    vecs[4]  = '{2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    vecs[5]  = '{2'b00, 64'd5, 64'd0, ONES};
    vecs[6]  = '{2'b11, 64'd5, 64'd0, 64'd5};
    vecs[7]  = '{2'b00, MIN, ONES, MIN};
    vecs[8]  = '{2'b10, MIN, ONES, 64'd0};
    vecs[9]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[10] = '{2'b01, ONES, 64'd1, ONES};
    vecs[11] = '{2'b00, MIN, 64'd1, MIN};
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    for (int i = 0; i < 150; i++) begin
      int mode;
      o = 2'($urandom_range(0, 3));
      a = {$urandom(), $urandom()};
      mode = $urandom_range(0, 4);
      b = mode == 0 ? {$urandom(), $urandom()} :
          mode == 1 ? 64'($urandom_range(0, 15)) :
          mode == 2 ? {$urandom(), $urandom()} >> $urandom_range(1, 63) :
          mode == 3 ? ($urandom_range(0, 1) ? ONES : 64'd0) :
                      -64'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) a = MIN;
      run($sformatf("rand%0d op%0d %h/%h", i, o, a, b), o, a, b, ref_model(o, a, b));
    end
    // start while busy is dropped; start held in the DONE cycle issues back-to-back
    issue(2'b01, 64'd100, 64'd7);
    dividend = 64'd9;
    divisor = 64'd3;
    nd = 0;
    first = -1;
    r14 = '0;
    for (int c = 0; c <= 64; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (done) begin
        nd++;
        first = c;
        r14 = result;
      end
      start = (c == 10 || c == 64);
    end
    chk("ignored start done count", 64'(nd), 64'd1);
    chk("ignored start done edge", 64'(first), 64'd64);
    chk("ignored start result", r14, 64'd14);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, b0);
    chk("back-to-back result", result, 64'd3);
    chk("back-to-back latency", 64'(lat), 64'd64);
    // abort mid-operation
    issue(2'b01, 64'd1000, 64'd10);
    repeat (19) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort no done", 64'(nd), 64'd0);
    chk("abort result held", result, 64'd3);
    // abort wins over start at the same edge
    @(negedge clk);
    op = 2'b01;
    dividend = 64'd50;
    divisor = 64'd5;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort over start busy", 64'(busy), 64'd0);
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort over start no done", 64'(nd), 64'd0);
    // asynchronous reset mid-operation
    issue(2'b01, 64'd1000, 64'd10);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    chk("async reset result", result, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("reset no done", 64'(nd), 64'd0);
    run("post-reset divu 81/9", 2'b01, 64'd81, 64'd9, 64'd9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
